// File: rtl/mux_sweep_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_sweep_sequencer_if
// Purpose : bundles the sweep control/status and the mux stimulus/response
//           signals of mux_sweep_sequencer into one port.
// Signals :
//   start      - begin a sweep (sampled by the sequencer only while idle)
//   F          - mux output returned to the sequencer
//   A, B       - mux data inputs (idx[0], idx[1])
//   D, C       - mux select low/high bits (idx[2], idx[3])
//   busy       - sweep in progress
//   done       - one-cycle completion pulse
//   pass       - response matched the expected truth table
//   response   - captured F, bit i for vector i
//   fail_index - lowest mismatching vector, 0 on pass
// Modports: slave = sequencer side, master = environment (controller + mux).
// -----------------------------------------------------------------------------
interface mux_sweep_sequencer_if;
  logic        start;
  logic        F;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] response;
  logic [3:0]  fail_index;

  modport slave (
    input  start, F,
    output A, B, C, D, busy, done, pass, response, fail_index
  );

  modport master (
    output start, F,
    input  A, B, C, D, busy, done, pass, response, fail_index
  );
endinterface

// File: rtl/mux_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sweep_sequencer
// Purpose : walks a 4-to-1 select-and-invert mux through all 16 input
//           combinations, holds each vector SETTLE_CYCLES cycles, samples F
//           into a 16-bit response word and compares it against EXPECTED.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mux_sweep_sequencer_if.slave (start/F in, stimulus and status out)
// Params  :
//   SETTLE_CYCLES - hold cycles per vector before sampling (1..255)
//   EXPECTED      - golden response word, bit i = F for vector i
// -----------------------------------------------------------------------------
module mux_sweep_sequencer #(
  parameter int unsigned  SETTLE_CYCLES = 4,
  parameter logic [15:0]  EXPECTED      = 16'h03C5
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_sweep_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_response;
  logic [3:0]  r_fail_index;

  logic [15:0] w_resp_cap;
  logic [15:0] w_diff;

  // Lowest set bit of the mismatch word; 0 when there is no mismatch.
  function automatic logic [3:0] first_mismatch(input logic [15:0] diff);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin
        pos = 4'(i);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  // Response word including the bit being captured this cycle, so pass and
  // fail_index can be registered on the same edge that enters DONE.
  always_comb begin
    w_resp_cap        = r_response;
    w_resp_cap[r_idx] = bus.F;
    w_diff            = w_resp_cap ^ EXPECTED;
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= 4'd0;
      r_cnt        <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_response   <= 16'h0000;
      r_fail_index <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state      <= ST_SETTLE;
            r_idx        <= 4'd0;
            r_cnt        <= 8'd0;
            r_busy       <= 1'b1;
            r_response   <= 16'h0000;
            r_pass       <= 1'b0;
            r_fail_index <= 4'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_state <= ST_SETTLE;
          end
        end

        ST_SAMPLE: begin
          r_response <= w_resp_cap;
          if (r_idx == 4'd15) begin
            // idx stays at 15 so the all-ones vector is held after the sweep.
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_pass       <= (w_diff == 16'h0000);
            r_fail_index <= first_mismatch(w_diff);
          end else begin
            r_state <= ST_SETTLE;
            r_idx   <= r_idx + 4'd1;
            r_cnt   <= 8'd0;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Stimulus bits come straight from the registered vector index.
  assign bus.A          = r_idx[0];
  assign bus.B          = r_idx[1];
  assign bus.D          = r_idx[2];
  assign bus.C          = r_idx[3];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.response   = r_response;
  assign bus.fail_index = r_fail_index;

endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_sweep_sequencer
// Drives directed sweeps against a behavioural mux (10-unit delay, Tclk=10).
// Each sweep pushes its hand-computed result into a queue; a monitor pops and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_mux_sweep_sequencer;

  localparam int SETTLE = 4;
  localparam int SWEEP  = 16 * (SETTLE + 1);   // done cycle offset: 80

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_sweep_sequencer_if bus ();

  mux_sweep_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .EXPECTED      (16'h03C5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 0 = correct mux, 1 = F stuck at 0, 2 = CD=01 branch returns ~B
  int mode = 0;

  function automatic logic mux_model(input int m, input logic a, input logic b,
                                     input logic c, input logic d);
    logic f;
    case ({c, d})
      2'b00:   f = ~a;
      2'b01:   f = (m == 2) ? ~b : b;
      2'b10:   f = ~b;
      default: f = 1'b0;
    endcase
    return (m == 1) ? 1'b0 : f;
  endfunction

  assign #10 bus.F = mux_model(mode, bus.A, bus.B, bus.C, bus.D);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] resp;
    logic        pass;
    logic [3:0]  fi;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: one expected entry per done cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("response",    32'(bus.response),   32'(e.resp));
        check("pass",        32'(bus.pass),       32'(e.pass));
        check("fail_index",  32'(bus.fail_index), 32'(e.fi));
        check("done_cycle",  32'(cyc),            32'(e.done_cyc));
        check("busy_at_done", 32'(bus.busy),      32'd0);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Start pulse on the next negedge; returns cyc at the drive point.
  // Cycle t=0 of the sweep then sits at cyc = k+1, done at cyc = k+1+SWEEP.
  task automatic pulse_start(output int k);
    @(negedge clk);
    k = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || bus.busy === 1'b1 || bus.done === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] r, input logic p, input logic [3:0] f, input int dc);
    exp_t e;
    e.resp = r; e.pass = p; e.fi = f; e.done_cyc = dc;
    q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_abcd"},  32'({bus.C, bus.D, bus.B, bus.A}), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_pass"},  32'(bus.pass),       32'd0);
    check({tag, "_resp"},  32'(bus.response),   32'd0);
    check({tag, "_fidx"},  32'(bus.fail_index), 32'd0);
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    bus.start = 1'b1;                // start with rst high must do nothing

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset_busy", 32'(bus.busy), 32'd0);

    // Golden sweep
    mode = 0;
    pulse_start(k);
    push(16'h03C5, 1'b1, 4'd0, k + 1 + SWEEP);
    wait_idle(300);
    check("abcd_hold_after_sweep", 32'({bus.C, bus.D, bus.B, bus.A}), 32'hF);

    // F stuck at 0: bit 0 expected 1 is the first mismatch
    mode = 1;
    repeat (3) @(negedge clk);
    pulse_start(k);
    push(16'h0000, 1'b0, 4'd0, k + 1 + SWEEP);
    wait_idle(300);

    // CD=01 returns ~B: vectors 4..7 give 1,1,0,0 instead of 0,0,1,1
    // -> nibble 1 becomes 4'h3, response 16'h0335, first mismatch at 4
    mode = 2;
    repeat (3) @(negedge clk);
    pulse_start(k);
    push(16'h0335, 1'b0, 4'd4, k + 1 + SWEEP);
    wait_idle(300);

    // Extra start pulses at t=10 and t=50 are ignored
    mode = 0;
    repeat (3) @(negedge clk);
    pulse_start(k);
    push(16'h03C5, 1'b1, 4'd0, k + 1 + SWEEP);
    wait_cyc(k + 1 + 10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(k + 1 + 50);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(300);

    // Start held high: second sweep's first busy cycle is t=82, done at t=162
    repeat (3) @(negedge clk);
    @(negedge clk);
    k = cyc;
    bus.start = 1'b1;
    push(16'h03C5, 1'b1, 4'd0, k + 1 + SWEEP);
    push(16'h03C5, 1'b1, 4'd0, k + 1 + 82 + SWEEP);
    wait_cyc(k + 1 + 81);
    check("held_start_gap_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_start_t82_busy", 32'(bus.busy), 32'd1);
    check("held_start_t82_abcd", 32'({bus.C, bus.D, bus.B, bus.A}), 32'd0);
    wait_cyc(k + 1 + 90);
    bus.start = 1'b0;
    wait_idle(400);

    // Reset mid-sweep at t=37 (vector 7, bits 0,2,6 captured so far)
    repeat (3) @(negedge clk);
    pulse_start(k);
    wait_cyc(k + 1 + 37);
    check("mid_abcd",    32'({bus.C, bus.D, bus.B, bus.A}), 32'h7);
    check("mid_resp",    32'(bus.response), 32'h0045);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (2) @(negedge clk);
    check("midrst_stays_idle", 32'(bus.busy), 32'd0);
    pulse_start(k);
    push(16'h03C5, 1'b1, 4'd0, k + 1 + SWEEP);
    wait_idle(300);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
